// File: rtl/guess_sequencer.sv
// Hangman front end: loads the secret word, then validates, de-duplicates
// and issues player guesses to the engine over the game_rdy handshake.
module guess_sequencer #(
  parameter int WORD_LEN    = 5,
  parameter int RDY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic [7:0]            host_byte,
  input  logic                  host_valid,
  input  logic [7:0]            player_byte,
  input  logic                  player_valid,
  input  logic                  new_game,
  input  logic                  game_rdy,
  input  logic                  red,
  input  logic                  green,
  output logic [8*WORD_LEN-1:0] set_word,
  output logic [7:0]            guess,
  output logic                  toggle_state,
  output logic                  player_ready,
  output logic                  reject,
  output logic                  dup,
  output logic                  timeout_err,
  output logic                  game_over,
  output logic [2:0]            phase
);

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    IDLE     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RDY = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int TW = $clog2(RDY_TIMEOUT + 1);
  localparam int IW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  state_t                state, state_n;
  logic [8*WORD_LEN-1:0] word_n;
  logic [7:0]            guess_n;
  logic [25:0]           mask, mask_n;
  logic [IW-1:0]         idx, idx_n;
  logic [TW-1:0]         timer, timer_n;
  logic                  first, first_n;
  logic                  tog_n, rej_n, dup_n, to_n;

  function automatic logic is_ltr(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic logic [7:0] to_up(input logic [7:0] b);
    return (b >= 8'h61) ? b - 8'h20 : b;
  endfunction

  logic [7:0] h_up, p_up, p_off, g_off;
  logic [4:0] p_bit, g_bit;

  assign h_up  = to_up(host_byte);
  assign p_up  = to_up(player_byte);
  assign p_off = p_up - 8'h41;
  assign g_off = guess - 8'h41;
  assign p_bit = p_off[4:0];
  assign g_bit = g_off[4:0];
  assign phase = state;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state        <= LOAD;
      set_word     <= '0;
      guess        <= '0;
      mask         <= '0;
      idx          <= '0;
      timer        <= '0;
      first        <= 1'b1;
      toggle_state <= 1'b0;
      player_ready <= 1'b0;
      reject       <= 1'b0;
      dup          <= 1'b0;
      timeout_err  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      set_word     <= word_n;
      guess        <= guess_n;
      mask         <= mask_n;
      idx          <= idx_n;
      timer        <= timer_n;
      first        <= first_n;
      toggle_state <= tog_n;
      player_ready <= (state_n == IDLE);
      reject       <= rej_n;
      dup          <= dup_n;
      timeout_err  <= to_n;
      game_over    <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    word_n  = set_word;
    guess_n = guess;
    mask_n  = mask;
    idx_n   = idx;
    timer_n = timer;
    first_n = first;
    tog_n   = 1'b0;
    rej_n   = 1'b0;
    dup_n   = 1'b0;
    to_n    = 1'b0;
    if (new_game) begin
      state_n = LOAD;
      mask_n  = '0;
      idx_n   = '0;
      word_n  = '0;
      first_n = 1'b1;
    end else begin
      unique case (state)
        LOAD: begin
          if (host_valid && is_ltr(host_byte)) begin
            word_n = {set_word[8*WORD_LEN-9:0], h_up};
            if (idx == IW'(WORD_LEN - 1)) begin
              idx_n   = '0;
              state_n = IDLE;
            end else begin
              idx_n = idx + IW'(1);
            end
          end else if (host_valid) begin
            rej_n = 1'b1;
          end
        end
        IDLE: begin
          if (green || red) begin
            state_n = DONE;
          end else if (player_valid) begin
            if (!is_ltr(player_byte)) begin
              rej_n = 1'b1;
            end else if (mask[p_bit]) begin
              dup_n = 1'b1;
            end else begin
              guess_n       = p_up;
              mask_n[p_bit] = 1'b1;
              timer_n       = '0;
              state_n       = ISSUE;
              tog_n         = first;
              first_n       = 1'b0;
            end
          end
        end
        ISSUE, WAIT_RDY: begin
          if (state == WAIT_RDY && (green || red)) begin
            state_n = DONE;
          end else if (state == ISSUE && !game_rdy) begin
            state_n = WAIT_RDY;
            timer_n = '0;
          end else if (state == WAIT_RDY && game_rdy) begin
            state_n = IDLE;
          end else begin
            // abandoning an issue frees the letter so the player may retry it
            if (timer == TW'(RDY_TIMEOUT - 1)) begin
              to_n          = 1'b1;
              mask_n[g_bit] = 1'b0;
              state_n       = IDLE;
            end
            if (timer != TW'(RDY_TIMEOUT)) timer_n = timer + TW'(1);
          end
        end
        DONE: ;
        default: state_n = LOAD;
      endcase
    end
  end

endmodule
